// File: rtl/task_map_pkg.sv
// Shared definitions for the task-graph streamer slice.
// Contents:
//   NUM_V_DEF / DATA_W_DEF : default graph size and edge-weight width
//   edge_w_t               : one edge weight at the default width
//   stream_state_t         : streamer FSM state encoding
package task_map_pkg;

  localparam int NUM_V_DEF  = 4;
  localparam int DATA_W_DEF = 32;

  typedef logic [DATA_W_DEF-1:0] edge_w_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ELEM0  = 3'd1,
    ST_ELEM1  = 3'd2,
    ST_POST   = 3'd3,
    ST_APPEND = 3'd4,
    ST_TAIL   = 3'd5
  } stream_state_t;

endpackage

// File: rtl/task_graph_store.sv
// NUM_V x NUM_V adjacency-matrix register array.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset (clears all entries)
//   wr_en            : write strobe (already qualified by the caller)
//   wr_row, wr_col   : write address
//   wr_data          : edge weight to store
//   rd_row, rd_col   : asynchronous read address
//   rd_data          : M[rd_row][rd_col]
module task_graph_store
  import task_map_pkg::*;
#(
  parameter int NUM_V  = NUM_V_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = $clog2(NUM_V)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_row,
  input  logic [IDX_W-1:0]  wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_row,
  input  logic [IDX_W-1:0]  rd_col,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [NUM_V][NUM_V];

  // Matrix storage: cleared on reset, one entry written per strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_V; r++) begin
        for (int c = 0; c < NUM_V; c++) begin
          mem_r[r][c] <= {DATA_W{1'b0}};
        end
      end
    end else if (wr_en) begin
      mem_r[wr_row][wr_col] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_row][rd_col];

endmodule

// File: rtl/task_graph_streamer.sv
// Transmitter end of the task-mapper input stream. Holds one task-graph
// adjacency matrix and replays it row-major num_apps times.
// Optional feature macro: SKIP_ZERO_EN -- zero entries take one cycle
// instead of two.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   wr_en/row/col/data : matrix load port, ignored while busy
//   start, num_apps    : launch pulse and replay count (sampled on start)
//   busy, done         : streaming in progress / one-cycle completion pulse
//   task_array, row, col, root_task, app_end : mapper stream interface
module task_graph_streamer
  import task_map_pkg::*;
#(
  parameter int NUM_V     = NUM_V_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int APP_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(NUM_V)-1:0] wr_row,
  input  logic [$clog2(NUM_V)-1:0] wr_col,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     start,
  input  logic [APP_CNT_W-1:0]     num_apps,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W-1:0]        task_array,
  output logic [$clog2(NUM_V)-1:0] row,
  output logic [$clog2(NUM_V)-1:0] col,
  output logic                     root_task,
  output logic                     app_end
);

  localparam int IDX_W = $clog2(NUM_V);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_V - 1);
  localparam logic [IDX_W-1:0]     IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1'b1);
  localparam logic [APP_CNT_W-1:0] CNT_ZERO = {APP_CNT_W{1'b0}};
  localparam logic [APP_CNT_W-1:0] CNT_ONE  = APP_CNT_W'(1'b1);
  localparam logic [DATA_W-1:0]    DATA_ZERO = {DATA_W{1'b0}};

  stream_state_t          state_r;
  logic [APP_CNT_W-1:0]   app_cnt_r;
  logic [IDX_W-1:0]       row_r, col_r;
  logic [DATA_W-1:0]      task_array_r;
  logic                   busy_r, done_r, root_task_r, app_end_r, root_seen_r;

  logic                   wr_acc_s;
  logic [IDX_W-1:0]       nxt_row_s, nxt_col_s;
  logic [DATA_W-1:0]      rd_data_s, entry_s;
  logic                   entry_nz_s, first_entry_s, root_nxt_s, seen_nxt_s;
  logic                   last_entry_s, advance_s, load_s;

  assign wr_acc_s = wr_en & ~busy_r;

  task_graph_store #(
    .NUM_V  (NUM_V),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc_s),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_row  (nxt_row_s),
    .rd_col  (nxt_col_s),
    .rd_data (rd_data_s)
  );

  // Address of the entry that would be presented next; (0,0) outside the matrix walk.
  always_comb begin
    nxt_row_s = IDX_ZERO;
    nxt_col_s = IDX_ZERO;
    if ((state_r == ST_ELEM0) || (state_r == ST_ELEM1)) begin
      if (col_r == IDX_LAST) begin
        nxt_row_s = row_r + IDX_ONE;
        nxt_col_s = IDX_ZERO;
      end else begin
        nxt_row_s = row_r;
        nxt_col_s = col_r + IDX_ONE;
      end
    end else begin
      nxt_row_s = IDX_ZERO;
      nxt_col_s = IDX_ZERO;
    end
  end

  // Next entry value and root tracking. A write landing on the same edge as
  // start is forwarded so the stream sees the updated matrix.
  always_comb begin
    entry_s = rd_data_s;
    if (wr_acc_s && (wr_row == nxt_row_s) && (wr_col == nxt_col_s)) begin
      entry_s = wr_data;
    end else begin
      entry_s = rd_data_s;
    end
    entry_nz_s    = (entry_s != DATA_ZERO);
    first_entry_s = (nxt_row_s == IDX_ZERO) && (nxt_col_s == IDX_ZERO);
    // Entry (0,0) opens a new application, so the root flag restarts there.
    root_nxt_s    = entry_nz_s & (first_entry_s | ~root_seen_r);
    seen_nxt_s    = first_entry_s ? entry_nz_s : (root_seen_r | entry_nz_s);
    last_entry_s  = (row_r == IDX_LAST) && (col_r == IDX_LAST);
  end

  // Decide whether the current entry is finished this cycle.
  always_comb begin
`ifdef SKIP_ZERO_EN
    advance_s = (state_r == ST_ELEM1) ||
                ((state_r == ST_ELEM0) && (task_array_r == DATA_ZERO));
`else
    advance_s = (state_r == ST_ELEM1);
`endif
  end

  // Cycles in which a fresh matrix entry is latched onto the outputs.
  always_comb begin
    load_s = 1'b0;
    case (state_r)
      ST_IDLE:  load_s = start && (num_apps != CNT_ZERO);
      ST_ELEM0,
      ST_ELEM1: load_s = advance_s && !last_entry_s;
      ST_TAIL:  load_s = (app_cnt_r != CNT_ZERO);
      default:  load_s = 1'b0;
    endcase
  end

  // Streamer FSM with registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      app_cnt_r    <= CNT_ZERO;
      row_r        <= IDX_ZERO;
      col_r        <= IDX_ZERO;
      task_array_r <= DATA_ZERO;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      root_task_r  <= 1'b0;
      app_end_r    <= 1'b0;
      root_seen_r  <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      app_end_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && (num_apps != CNT_ZERO)) begin
            state_r   <= ST_ELEM0;
            busy_r    <= 1'b1;
            app_cnt_r <= num_apps;
          end else if (start) begin
            done_r <= 1'b1;
          end
        end
        ST_ELEM0, ST_ELEM1: begin
          if (!advance_s) begin
            state_r <= ST_ELEM1;
          end else if (last_entry_s) begin
            state_r      <= ST_POST;
            task_array_r <= DATA_ZERO;
            root_task_r  <= 1'b0;
          end else begin
            state_r <= ST_ELEM0;
          end
        end
        ST_POST: begin
          state_r   <= ST_APPEND;
          app_end_r <= 1'b1;
        end
        ST_APPEND: begin
          // The counter drops on entry to TAIL so the final TAIL cycle can
          // already show done and a released busy.
          state_r   <= ST_TAIL;
          app_cnt_r <= app_cnt_r - CNT_ONE;
          if (app_cnt_r == CNT_ONE) begin
            done_r <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        ST_TAIL: begin
          if (app_cnt_r != CNT_ZERO) begin
            state_r <= ST_ELEM0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
      if (load_s) begin
        row_r        <= nxt_row_s;
        col_r        <= nxt_col_s;
        task_array_r <= entry_s;
        root_task_r  <= root_nxt_s;
        root_seen_r  <= seen_nxt_s;
      end
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign task_array = task_array_r;
  assign row        = row_r;
  assign col        = col_r;
  assign root_task  = root_task_r;
  assign app_end    = app_end_r;

endmodule
